// File: rtl/aes_pkg.sv
// Shared AES-128 key-expansion types, S-box/Rcon tables and word helpers,
// used by both the encrypt expander and the inverse key stream.
package aes_pkg;

  typedef logic [0:127] aes_key128_t;
  typedef logic [31:0]  aes_word_t;

  localparam logic [7:0] AES_SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic aes_word_t fn_rot_word(input aes_word_t w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic aes_word_t fn_sub_word(input aes_word_t w);
    return {AES_SBOX[w[31:24]], AES_SBOX[w[23:16]], AES_SBOX[w[15:8]], AES_SBOX[w[7:0]]};
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Four parallel AES S-box lookups on one 32-bit word, purely combinational.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] word,
  output logic [31:0] sub
);

  assign sub = fn_sub_word(word);

endmodule

// File: rtl/aes_inv_key_stream.sv
// Iterative AES-128 inverse key expander: takes the round-10 key and streams
// round keys 10..0 on a valid/ready port. Define AES_INV_KS_FULL_SCHED_EN to
// also collect the whole schedule into o_key_schedule with an o_sched_valid pulse.
//
// state   | meaning
// ST_IDLE | waiting for a round-10 key (i_ready high once out of reset)
// ST_EMIT | presenting round key o_round, stepping back on each transfer
module aes_inv_key_stream
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_valid,
  output logic          i_ready,
  input  logic [0:127]  i_last_key,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [0:127]  o_round_key,
  output logic [3:0]    o_round,
  output logic          o_last
`ifdef AES_INV_KS_FULL_SCHED_EN
  ,
  output logic [0:1407] o_key_schedule,
  output logic          o_sched_valid
`endif
);

  if (NUM_ROUNDS != 10) begin : g_bad_rounds
    $error("aes_inv_key_stream supports only NUM_ROUNDS = 10");
  end

  typedef enum logic {ST_IDLE, ST_EMIT} state_t;

  state_t      state, state_nxt;
  aes_key128_t key_q;
  logic [3:0]  round_q;
  logic        armed;
  logic        accept, xfer;
  aes_word_t   c0, c1, c2, c3, p0, p1, p2, p3;
  aes_word_t   rot_p3, sub_rot;
  logic [7:0]  rcon_byte;

  // armed keeps i_ready low until the first clock after reset release
  assign i_ready     = armed && (state == ST_IDLE);
  assign o_valid     = (state == ST_EMIT);
  assign o_round_key = key_q;
  assign o_round     = round_q;
  assign o_last      = o_valid && (round_q == 4'd0);
  assign accept      = i_valid && i_ready;
  assign xfer        = o_valid && o_ready;

  assign {c0, c1, c2, c3} = key_q;
  assign p3     = c3 ^ c2;
  assign p2     = c2 ^ c1;
  assign p1     = c1 ^ c0;
  assign rot_p3 = fn_rot_word(p3);

  aes_sub_word u_sub_word (
    .word (rot_p3),
    .sub  (sub_rot)
  );

  always_comb begin
    rcon_byte = 8'h00;
    if (round_q >= 4'd1 && round_q <= 4'd10) rcon_byte = RCON[round_q];
  end

  assign p0 = c0 ^ sub_rot ^ {rcon_byte, 24'h0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)         state_nxt = ST_EMIT;
      ST_EMIT: if (xfer && o_last) state_nxt = ST_IDLE;
      default:                     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q   <= '0;
      round_q <= 4'd0;
    end else if (accept) begin
      key_q   <= i_last_key;
      round_q <= 4'(NUM_ROUNDS);
    end else if (xfer && round_q != 4'd0) begin
      key_q   <= {p0, p1, p2, p3};
      round_q <= round_q - 4'd1;
    end
  end

`ifdef AES_INV_KS_FULL_SCHED_EN
  logic [0:1407] sched_q;
  logic          sched_valid_q;

  // round r lands at [128*r +: 128], so round 0 leads like the encrypt schedule
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sched_q       <= '0;
      sched_valid_q <= 1'b0;
    end else begin
      sched_valid_q <= xfer && o_last;
      if (accept)    sched_q <= '0;
      else if (xfer) sched_q[128*round_q +: 128] <= key_q;
    end
  end

  assign o_key_schedule = sched_q;
  assign o_sched_valid  = sched_valid_q;
`endif

endmodule

// File: tb/tb_aes_inv_key_stream.sv
// Scoreboard bench for aes_inv_key_stream: expected keys come from a forward
// key-expansion model and are queued when a key is offered.
module tb_aes_inv_key_stream;
  import aes_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_valid = 1'b0;
  logic         o_ready = 1'b0;
  logic [0:127] i_last_key = '0;
  logic         i_ready, o_valid, o_last;
  logic [0:127] o_round_key;
  logic [3:0]   o_round;
`ifdef AES_INV_KS_FULL_SCHED_EN
  logic [0:1407] o_key_schedule;
  logic          o_sched_valid;
`endif

  int n_vec = 0;
  int n_bad = 0;
  logic [127:0] exp_q [$];
  logic [127:0] rk_m [0:10];

  always #5 clk = ~clk;

  aes_inv_key_stream dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_valid     (i_valid),
    .i_ready     (i_ready),
    .i_last_key  (i_last_key),
    .o_valid     (o_valid),
    .o_ready     (o_ready),
    .o_round_key (o_round_key),
    .o_round     (o_round),
    .o_last      (o_last)
`ifdef AES_INV_KS_FULL_SCHED_EN
    ,
    .o_key_schedule (o_key_schedule),
    .o_sched_valid  (o_sched_valid)
`endif
  );

  function automatic logic [31:0] m_sub(input logic [31:0] w);
    return {AES_SBOX[w[31:24]], AES_SBOX[w[23:16]], AES_SBOX[w[15:8]], AES_SBOX[w[7:0]]};
  endfunction

  // forward FIPS-197 expansion; rcon generated by xtime rather than a table
  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = m_sub({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_m[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic push_expected;
    for (int r = 10; r >= 0; r--) exp_q.push_back(rk_m[r]);
  endtask

  function automatic logic [127:0] rnd_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // returns at the negedge following the accept edge
  task automatic offer_key(input logic [127:0] k, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    i_valid = 1'b1;
    i_last_key = k;
    for (int c = 0; c < 40 && !ok; c++) begin
      if (i_ready) ok = 1'b1;
      @(negedge clk);
    end
    i_valid = 1'b0;
    if (!ok) begin
      n_vec++; n_bad++;
      $display("FAIL accept_timeout: i_ready=%b after 40 cycles, want 1", i_ready);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (i_ready !== 1'b0 || o_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_handshake: i_ready=%b o_valid=%b, want 0 0", i_ready, o_valid);
    end
    n_vec++;
    if (o_round_key !== '0 || o_round !== 4'd0 || o_last !== 1'b0) begin
      n_bad++; $display("FAIL reset_outputs: key=%h round=%0d last=%b, want 0 0 0", o_round_key, o_round, o_last);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (i_ready !== 1'b1) begin
      n_bad++; $display("FAIL ready_after_release: i_ready=%b, want 1", i_ready);
    end
  endtask

  task automatic test_fips_a1;
    logic [127:0] exp, known;
    int beat;
    bit ok;
`ifdef AES_INV_KS_FULL_SCHED_EN
    logic [0:1407] full;
`endif
    o_ready = 1'b1;
    model_expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
    push_expected();
    offer_key(128'hd014f9a8c9ee2589e13f0cc8b6630ca6, ok);
    beat = 0;
    for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
      if (o_valid && o_ready) begin
        exp = exp_q.pop_front();
        n_vec++;
        if (o_round_key !== exp || o_round !== 4'(10 - beat) || o_last !== (beat == 10)) begin
          n_bad++;
          $display("FAIL a1_beat%0d: got key=%h round=%0d last=%b, want key=%h round=%0d last=%b",
                   beat, o_round_key, o_round, o_last, exp, 10 - beat, beat == 10);
        end
        if (beat inside {0, 1, 9, 10}) begin
          case (beat)
            0:       known = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
            1:       known = 128'hac7766f319fadc2128d12941575c006e;
            9:       known = 128'ha0fafe1788542cb123a339392a6c7605;
            default: known = 128'h2b7e151628aed2a6abf7158809cf4f3c;
          endcase
          n_vec++;
          if (o_round_key !== known) begin
            n_bad++; $display("FAIL a1_known%0d: got %h, want %h", beat, o_round_key, known);
          end
        end
        beat++;
      end
      @(negedge clk);
    end
    n_vec++;
    if (exp_q.size() != 0 || o_valid !== 1'b0 || i_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL a1_end: pending=%0d o_valid=%b i_ready=%b, want 0 0 1", exp_q.size(), o_valid, i_ready);
      exp_q.delete();
    end
`ifdef AES_INV_KS_FULL_SCHED_EN
    for (int r = 0; r < 11; r++) full[128*r +: 128] = rk_m[r];
    n_vec++;
    if (o_sched_valid !== 1'b1 || o_key_schedule[0:127] !== 128'h2b7e151628aed2a6abf7158809cf4f3c ||
        o_key_schedule[1280:1407] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      n_bad++;
      $display("FAIL sched_ends: valid=%b r0=%h r10=%h, want 1 2b7e151628aed2a6abf7158809cf4f3c d014f9a8c9ee2589e13f0cc8b6630ca6",
               o_sched_valid, o_key_schedule[0:127], o_key_schedule[1280:1407]);
    end
    n_vec++;
    if (o_key_schedule !== full) begin
      n_bad++; $display("FAIL sched_full: schedule differs from forward expansion");
    end
    @(negedge clk);
    n_vec++;
    if (o_sched_valid !== 1'b0) begin
      n_bad++; $display("FAIL sched_pulse: o_sched_valid=%b one cycle later, want 0", o_sched_valid);
    end
`endif
  endtask

  task automatic test_backpressure;
    logic [127:0] exp, hk;
    logic [3:0]   hr;
    logic         hl;
    bit           stall, ok;
    int           beat, extra;
    model_expand(rnd_key());
    push_expected();
    o_ready = 1'b0;
    offer_key(rk_m[10], ok);
`ifdef AES_INV_KS_FULL_SCHED_EN
    n_vec++;
    if (o_key_schedule !== '0) begin
      n_bad++; $display("FAIL sched_clear: schedule nonzero after accept, want 0");
    end
`endif
    stall = 1'b0; beat = 0; hk = '0; hr = '0; hl = 1'b0;
    for (int c = 0; c < 300 && exp_q.size() > 0; c++) begin
      if (stall) begin
        n_vec++;
        if (o_valid !== 1'b1 || o_round_key !== hk || o_round !== hr || o_last !== hl) begin
          n_bad++;
          $display("FAIL stall_hold: got v=%b key=%h round=%0d last=%b, want v=1 key=%h round=%0d last=%b",
                   o_valid, o_round_key, o_round, o_last, hk, hr, hl);
        end
      end
      o_ready = 1'($urandom_range(0, 1));
      if (o_valid && o_ready) begin
        exp = exp_q.pop_front();
        n_vec++;
        if (o_round_key !== exp || o_round !== 4'(10 - beat)) begin
          n_bad++;
          $display("FAIL bp_beat%0d: got key=%h round=%0d, want key=%h round=%0d", beat, o_round_key, o_round, exp, 10 - beat);
        end
        beat++;
      end
      stall = o_valid && !o_ready;
      hk = o_round_key; hr = o_round; hl = o_last;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      n_vec++; n_bad++;
      $display("FAIL bp_timeout: %0d beats outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
    o_ready = 1'b1;
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      if (o_valid) extra++;
      @(negedge clk);
    end
    n_vec++;
    if (extra != 0) begin
      n_bad++; $display("FAIL bp_extra_beats: %0d valid cycles after 11 beats, want 0", extra);
    end
  endtask

  task automatic test_back_to_back;
    logic [127:0] ka, kb, exp;
    bit gap_next, drop_next, second;
    ka = rnd_key(); kb = rnd_key();
    model_expand(ka); push_expected();
    model_expand(kb); push_expected();
    ka = exp_q[0];
    kb = exp_q[11];
    o_ready = 1'b1;
    @(negedge clk);
    i_valid = 1'b1;
    i_last_key = ka;
    gap_next = 1'b0; drop_next = 1'b0; second = 1'b0;
    for (int c = 0; c < 80 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (gap_next) begin
        n_vec++;
        if (i_ready !== 1'b1 || o_valid !== 1'b0) begin
          n_bad++; $display("FAIL b2b_gap: i_ready=%b o_valid=%b, want 1 0", i_ready, o_valid);
        end
        gap_next = 1'b0; drop_next = 1'b1;
      end else if (drop_next) begin
        n_vec++;
        if (o_valid !== 1'b1 || o_round !== 4'd10) begin
          n_bad++; $display("FAIL b2b_accept: o_valid=%b round=%0d, want 1 10", o_valid, o_round);
        end
        i_valid = 1'b0; drop_next = 1'b0;
      end
      if (o_valid) begin
        i_last_key = kb;
        n_vec++;
        if (i_ready !== 1'b0) begin
          n_bad++; $display("FAIL emit_ready: i_ready=%b during EMIT, want 0", i_ready);
        end
      end
      if (o_valid && o_ready) begin
        exp = exp_q.pop_front();
        n_vec++;
        if (o_round_key !== exp) begin
          n_bad++; $display("FAIL b2b_key: got %h round=%0d, want %h", o_round_key, o_round, exp);
        end
        if (o_last && !second) begin gap_next = 1'b1; second = 1'b1; end
      end
    end
    i_valid = 1'b0;
    if (exp_q.size() != 0) begin
      n_vec++; n_bad++;
      $display("FAIL b2b_timeout: %0d beats outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_mid_reset;
    logic [127:0] exp;
    bit ok;
    int beat;
    model_expand(rnd_key()); push_expected();
    o_ready = 1'b1;
    offer_key(rk_m[10], ok);
    beat = 0;
    for (int c = 0; c < 20 && beat < 5; c++) begin
      if (o_valid && o_ready) begin
        exp = exp_q.pop_front();
        n_vec++;
        if (o_round_key !== exp) begin
          n_bad++; $display("FAIL mr_pre_key%0d: got %h, want %h", beat, o_round_key, exp);
        end
        beat++;
      end
      @(negedge clk);
    end
    n_vec++;
    if (o_valid !== 1'b1 || o_round !== 4'd5) begin
      n_bad++; $display("FAIL mr_position: o_valid=%b round=%0d, want 1 5", o_valid, o_round);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (o_valid !== 1'b0 || i_ready !== 1'b0 || o_round_key !== '0 || o_last !== 1'b0) begin
      n_bad++;
      $display("FAIL mr_async: o_valid=%b i_ready=%b key=%h last=%b, want 0 0 0 0", o_valid, i_ready, o_round_key, o_last);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    n_vec++;
    if (o_valid !== 1'b0) begin
      n_bad++; $display("FAIL mr_release_valid: o_valid=%b, want 0", o_valid);
    end
    @(negedge clk);
    n_vec++;
    if (i_ready !== 1'b1 || o_valid !== 1'b0) begin
      n_bad++; $display("FAIL mr_after_release: i_ready=%b o_valid=%b, want 1 0", i_ready, o_valid);
    end
    model_expand(rnd_key()); push_expected();
    offer_key(rk_m[10], ok);
    beat = 0;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      if (o_valid && o_ready) begin
        exp = exp_q.pop_front();
        n_vec++;
        if (o_round_key !== exp || o_round !== 4'(10 - beat)) begin
          n_bad++;
          $display("FAIL mr_post_beat%0d: got key=%h round=%0d, want key=%h round=%0d", beat, o_round_key, o_round, exp, 10 - beat);
        end
        beat++;
      end
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      n_vec++; n_bad++;
      $display("FAIL mr_timeout: %0d beats outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_round_trip;
    logic [127:0] k, exp, r0;
    bit ok, got;
    o_ready = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      k = (n == 0) ? 128'h0 : rnd_key();
      model_expand(k); push_expected();
      offer_key(rk_m[10], ok);
      for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
        if (o_valid && o_ready) begin
          exp = exp_q.pop_front();
          n_vec++;
          if (o_round_key !== exp) begin
            n_bad++; $display("FAIL rt_key%0d: got %h round=%0d, want %h", n, o_round_key, o_round, exp);
          end
        end
        @(negedge clk);
      end
      if (exp_q.size() != 0) begin
        n_vec++; n_bad++;
        $display("FAIL rt_timeout%0d: %0d beats outstanding, want 0", n, exp_q.size());
        exp_q.delete();
      end
    end
    // all-zero round-10 key: forward-expanding the emitted round 0 must give it back
    offer_key(128'h0, ok);
    got = 1'b0; r0 = '0;
    for (int c = 0; c < 20 && !got; c++) begin
      if (o_valid && o_last) begin r0 = o_round_key; got = 1'b1; end
      @(negedge clk);
    end
    model_expand(r0);
    n_vec++;
    if (!got || rk_m[10] !== 128'h0) begin
      n_bad++; $display("FAIL zero_round_trip: got_last=%b fwd(r0)=%h, want 1 0", got, rk_m[10]);
    end
  endtask

  initial begin
    test_reset();
    test_fips_a1();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    test_round_trip();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
